icache_assoc: RTL and testbench

- Parametrised set-associative instruction cache between the datapath fetch port and the memory controller's instruction channel.
- Supports a configurable number of sets, ways and words per block.
- Uses true-LRU replacement and multi-word block fills.
- Provides a whole-cache invalidate (flush) that is safe during an outstanding fill.

---
 rtl/cpu_types_pkg.sv | 41 ++++
 rtl/icache_lru_set.sv | 57 +++++
 rtl/icache_assoc.sv | 219 +++++++++++++++++++++
 tb/tb_icache_assoc.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: default geometry, address and line
// layouts, FSM state encoding and a field-width helper.
package cpu_types_pkg;

    // Default cache geometry
    localparam int ICACHE_SETS  = 8;
    localparam int ICACHE_WAYS  = 2;
    localparam int ICACHE_WORDS = 2;

    // Field widths of the default geometry, LSB first: byte, word, index, tag
    localparam int ICACHE_WORD_W  = $clog2(ICACHE_WORDS);
    localparam int ICACHE_INDEX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W   = 32 - 2 - ICACHE_WORD_W - ICACHE_INDEX_W;

    // Fetch address split for the default geometry
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0]   tag;
        logic [ICACHE_INDEX_W-1:0] index;
        logic [ICACHE_WORD_W-1:0]  word;
        logic [1:0]                byte_off;
    } icache_addr_t;

    // Per-line bookkeeping for the default geometry
    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
    } icache_line_t;

    // Cache controller states
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    // Width of a field that selects one of n items; never narrower than one
    // bit so that degenerate geometries (one way, one word) still elaborate.
    function automatic int icache_field_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_lru_set.sv
// True-LRU age vector for one cache set. Age 0 is most recently used,
// WAYS-1 is least recently used; the ages always form a permutation.
module icache_lru_set
    import cpu_types_pkg::*;
#(
    parameter int WAYS = ICACHE_WAYS,
    localparam int WAY_W = icache_field_w(WAYS)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             touch,
    input  logic [WAY_W-1:0] touch_way,
    output logic [WAY_W-1:0] victim
);

    generate
        if (WAYS == 1) begin : g_direct
            // Direct-mapped: nothing to age, the only way is always the victim
            logic touch_unused;
            assign touch_unused = touch ^ touch_way[0];
            assign victim = '0;
        end else begin : g_lru
            logic [WAY_W-1:0] age_reg [WAYS];
            logic [WAY_W-1:0] touch_age;

            assign touch_age = age_reg[touch_way];

            // Touched way becomes MRU; ways younger than it age by one
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    for (int w = 0; w < WAYS; w++) begin
                        age_reg[w] <= WAY_W'(w);
                    end
                end else if (touch) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (touch_way == WAY_W'(w)) begin
                            age_reg[w] <= '0;
                        end else if (age_reg[w] < touch_age) begin
                            age_reg[w] <= age_reg[w] + WAY_W'(1);
                        end
                    end
                end
            end

            // Victim is the unique way holding the oldest age
            always_comb begin
                victim = '0;
                for (int w = 0; w < WAYS; w++) begin
                    if (age_reg[w] == WAY_W'(WAYS - 1)) begin
                        victim = WAY_W'(w);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache between the fetch port and the memory
// instruction channel. Zero-latency combinational hits, multi-word block
// fills, true-LRU replacement and a flush that waits out an active fill.
module icache_assoc
    import cpu_types_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int WAYS  = ICACHE_WAYS,
    parameter int WORDS = ICACHE_WORDS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        iflush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int WORD_W  = $clog2(WORDS);
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = 32 - 2 - WORD_W - INDEX_W;
    localparam int CNT_W   = icache_field_w(WORDS);
    localparam int WAY_W   = icache_field_w(WAYS);

    // Same shape as icache_line_t, sized from this instance's parameters
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } line_t;

    // Storage: line bookkeeping in flops (reset/flush clear them), data
    // words in a separate array that needs no reset.
    line_t       line_reg [SETS][WAYS];
    logic [31:0] data_mem [SETS][WAYS][WORDS];

    icache_state_t      state_reg, state_next;
    logic [CNT_W-1:0]   word_cnt_reg;
    logic [TAG_W-1:0]   fill_tag_reg;
    logic [INDEX_W-1:0] fill_index_reg;
    logic [WAY_W-1:0]   victim_reg;
    logic               flush_pending_reg;

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_index;
    logic [CNT_W-1:0]   addr_word;
    logic [31:0]        fill_addr;

    logic [WAYS-1:0]    way_hit;
    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [WAY_W-1:0]   victim_next;
    logic [WAY_W-1:0]   lru_victim [SETS];

    logic               fill_start;
    logic               fill_beat;
    logic               fill_done;
    logic               flush_now;
    logic               touch;
    logic [INDEX_W-1:0] touch_set;
    logic [WAY_W-1:0]   touch_way;

    // Fetch address split
    assign addr_tag   = imemaddr[31 -: TAG_W];
    assign addr_index = imemaddr[2 + WORD_W +: INDEX_W];

    generate
        if (WORDS > 1) begin : g_multi_word
            assign addr_word = imemaddr[2 +: WORD_W];
            assign fill_addr = {fill_tag_reg, fill_index_reg, word_cnt_reg, 2'b00};
        end else begin : g_single_word
            assign addr_word = '0;
            assign fill_addr = {fill_tag_reg, fill_index_reg, 2'b00};
        end
    endgenerate

    // Tag compare across the indexed set
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way_cmp
            assign way_hit[gi] = line_reg[addr_index][gi].valid &&
                                 (line_reg[addr_index][gi].tag == addr_tag);
        end
    endgenerate

    // Encode the hitting way (at most one way can match)
    always_comb begin
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w]) begin
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit      = (state_reg == IDLE) && (|way_hit);
    assign ihit     = imemREN && hit;
    assign imemload = hit ? data_mem[addr_index][hit_way][addr_word] : '0;

    // Victim: lowest-numbered invalid way, otherwise the set's LRU way
    always_comb begin
        victim_next = lru_victim[addr_index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!line_reg[addr_index][w].valid) begin
                victim_next = WAY_W'(w);
            end
        end
    end

    // A hit and a fill completion never coincide (different states)
    assign touch     = ihit || fill_done;
    assign touch_set = fill_done ? fill_index_reg : addr_index;
    assign touch_way = fill_done ? victim_reg : hit_way;

    generate
        for (gi = 0; gi < SETS; gi++) begin : g_lru
            icache_lru_set #(
                .WAYS(WAYS)
            ) u_lru (
                .CLK      (CLK),
                .nRST     (nRST),
                .touch    (touch && (touch_set == INDEX_W'(gi))),
                .touch_way(touch_way),
                .victim   (lru_victim[gi])
            );
        end
    endgenerate

    // Next state and memory-channel outputs
    always_comb begin
        state_next = state_reg;
        iREN       = 1'b0;
        iaddr      = imemaddr;
        fill_start = 1'b0;
        fill_beat  = 1'b0;
        fill_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (imemREN && !hit && !flush_pending_reg) begin
                    fill_start = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = fill_addr;
                if (!iwait) begin
                    fill_beat = 1'b1;
                    if (word_cnt_reg == CNT_W'(WORDS - 1)) begin
                        fill_done  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, fill context and deferred-flush flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg         <= IDLE;
            word_cnt_reg      <= '0;
            fill_tag_reg      <= '0;
            fill_index_reg    <= '0;
            victim_reg        <= '0;
            flush_pending_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (fill_start) begin
                fill_tag_reg   <= addr_tag;
                fill_index_reg <= addr_index;
                victim_reg     <= victim_next;
                word_cnt_reg   <= '0;
            end else if (fill_beat) begin
                word_cnt_reg <= fill_done ? '0 : word_cnt_reg + CNT_W'(1);
            end
            if ((state_reg == FILL) && iflush) begin
                flush_pending_reg <= 1'b1;
            end else if (state_reg == IDLE) begin
                flush_pending_reg <= 1'b0;
            end
        end
    end

    // A flush only takes effect in IDLE so an active fill is never cut short
    assign flush_now = (state_reg == IDLE) && (iflush || flush_pending_reg);

    // Line valid/tag: clear on reset or flush, install on fill completion
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    line_reg[s][w] <= '0;
                end
            end
        end else if (flush_now) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    line_reg[s][w].valid <= 1'b0;
                end
            end
        end else if (fill_done) begin
            line_reg[fill_index_reg][victim_reg] <= '{valid: 1'b1, tag: fill_tag_reg};
        end
    end

    // Data words arrive one per accepted memory beat
    always_ff @(posedge CLK) begin
        if (fill_beat) begin
            data_mem[fill_index_reg][victim_reg][word_cnt_reg] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc (default geometry: 8 sets, 2 ways,
// 2 words). Stimulus queues expected hits and memory beats; a monitor
// compares them as the DUT presents ihit or iREN.
module tb_icache_assoc;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iflush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int          checks = 0;
    int          errors = 0;
    int          lat = 0;
    logic [31:0] salt = 32'h0000_0000;
    int          wait_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } hit_exp_t;

    hit_exp_t    hit_q[$];
    logic [31:0] mem_q[$];

    icache_assoc dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .imemREN (imemREN),
        .imemaddr(imemaddr),
        .ihit    (ihit),
        .imemload(imemload),
        .iflush  (iflush),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory contents: a fixed scramble of the word address, varied by salt
    function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
        return (a * 32'h9E37_79B1) ^ s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: each word needs `lat` wait cycles before it is granted
    initial begin
        iwait = 1'b1;
        iload = 32'h0;
        forever begin
            @(negedge CLK);
            if (iREN) begin
                if (wait_cnt >= lat) begin
                    iwait    = 1'b0;
                    iload    = mem_word(iaddr, salt);
                    wait_cnt = 0;
                end else begin
                    iwait    = 1'b1;
                    iload    = 32'hDEAD_BEEF;
                    wait_cnt++;
                end
            end else begin
                iwait    = 1'b1;
                iload    = 32'hDEAD_BEEF;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: checks every hit against hit_q and every memory cycle against mem_q
    initial begin
        hit_exp_t e;
        forever begin
            @(negedge CLK);
            #1;
            if (!nRST) continue;
            if (ihit) begin
                if (hit_q.size() == 0) begin
                    chk("unexpected_ihit", {31'b0, ihit}, 32'h0);
                end else begin
                    e = hit_q.pop_front();
                    chk("imemload", imemload, e.data);
                end
            end
            if (iREN) begin
                if (mem_q.size() == 0) begin
                    chk("unexpected_iREN", {31'b0, iREN}, 32'h0);
                end else begin
                    chk("iaddr", iaddr, mem_q[0]);
                    if (!iwait) void'(mem_q.pop_front());
                end
            end
        end
    end

    task automatic push_beats(input logic [31:0] addr);
        mem_q.push_back(addr & 32'hFFFF_FFF8);
        mem_q.push_back((addr & 32'hFFFF_FFF8) + 32'd4);
    endtask

    task automatic do_reset();
        nRST    = 1'b0;
        imemREN = 1'b0;
        iflush  = 1'b0;
        repeat (2) @(negedge CLK);
        mem_q.delete();
        hit_q.delete();
        nRST = 1'b1;
    endtask

    // One fetch held until ihit; exp_pen is the expected miss penalty (0 = hit).
    // flush_at: cycle after which iflush pulses for one cycle (0 = with the address).
    task automatic fetch(input logic [31:0] addr, input int exp_pen, input int flush_at);
        int cyc;
        bit seen;
        @(negedge CLK);
        hit_q.push_back('{addr: addr, data: mem_word(addr, salt)});
        if (exp_pen > 0) push_beats(addr);
        imemREN  = 1'b1;
        imemaddr = addr;
        iflush   = (flush_at == 0);
        cyc  = 0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            #1;
            cyc++;
            if (ihit) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
            iflush = (cyc == flush_at);
        end
        @(negedge CLK);
        imemREN = 1'b0;
        iflush  = 1'b0;
        chk("hit_seen", {31'b0, seen}, 32'd1);
        chk("miss_penalty", cyc - 1, exp_pen);
        $display("fetch addr=%h penalty=%0d", addr, cyc - 1);
    endtask

    // Wait (bounded) for the first granted memory beat of the current fill
    task automatic wait_first_beat(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (iREN && !iwait) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk(name, {31'b0, seen}, 32'd1);
    endtask

    // Fill started, then the fetch request is withdrawn after the first word
    task automatic fetch_drop(input logic [31:0] addr);
        bit seen;
        @(negedge CLK);
        push_beats(addr);
        imemREN  = 1'b1;
        imemaddr = addr;
        wait_first_beat("drop_first_beat");
        @(negedge CLK);
        imemREN  = 1'b0;
        imemaddr = 32'h0000_0300;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (!iREN) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        chk("drop_fill_returns", {31'b0, seen}, 32'd1);
        chk("drop_idle_iaddr", iaddr, 32'h0000_0300);
        chk("drop_beats_done", mem_q.size(), 32'd0);
        $display("fetch_drop addr=%h", addr);
    endtask

    initial begin
        nRST     = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h1234_5670;
        iflush   = 1'b0;
        #1 nRST  = 1'b0;
        #2;
        // Reset state
        chk("rst_iREN", {31'b0, iREN}, 32'd0);
        chk("rst_ihit", {31'b0, ihit}, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iaddr", iaddr, 32'h1234_5670);
        do_reset();

        // Cold miss then hits on both words of the block
        fetch(32'h0000_0040, 3, -1);
        fetch(32'h0000_0040, 0, -1);
        fetch(32'h0000_0044, 0, -1);

        // Slow memory: three wait cycles per word
        do_reset();
        lat = 3;
        fetch(32'h0000_0040, 9, -1);
        lat = 0;

        // Conflict in set 0 and LRU replacement
        do_reset();
        fetch(32'h0000_0000, 3, -1);
        fetch(32'h0000_0040, 3, -1);
        fetch(32'h0000_0000, 0, -1);
        fetch(32'h0000_0080, 3, -1);
        fetch(32'h0000_0000, 0, -1);
        fetch(32'h0000_0040, 3, -1);

        // Request withdrawn mid-fill; fill still completes
        fetch_drop(32'h0000_0100);
        fetch(32'h0000_0100, 0, -1);
        fetch(32'h0000_0104, 0, -1);
        fetch(32'h0000_0040, 0, -1);

        // Flush during a fill: fill finishes and hits once, then everything invalid
        fetch(32'h0000_0200, 3, 1);
        salt = 32'h5A5A_0001;
        fetch(32'h0000_0040, 3, -1);
        fetch(32'h0000_0200, 3, -1);
        // Flush in IDLE alongside a hit: hit uses pre-flush contents
        fetch(32'h0000_0200, 0, 0);
        fetch(32'h0000_0040, 3, -1);

        // Reset asserted during the second fill word
        lat = 2;
        do_reset();
        @(negedge CLK);
        push_beats(32'h0000_0040);
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0040;
        wait_first_beat("rst_fill_first_beat");
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("midfill_rst_iREN", {31'b0, iREN}, 32'd0);
        chk("midfill_rst_ihit", {31'b0, ihit}, 32'd0);
        chk("midfill_rst_iaddr", iaddr, 32'h0000_0040);
        mem_q.delete();
        @(negedge CLK);
        imemREN = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        fetch(32'h0000_0040, 7, -1);
        lat = 0;

        repeat (3) @(negedge CLK);
        chk("hit_q_drained", hit_q.size(), 32'd0);
        chk("mem_q_drained", mem_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound on run time
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
